countdown_alarm_ctrl: RTL and testbench

//  Sequences the board's countdown/alarm datapath: loads a preset, counts it down once per second,

---
 rtl/countdown_alarm_ctrl.sv | 147 ++++++++++++++
 tb/tb_countdown_alarm_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_alarm_ctrl.sv
// Countdown/alarm sequencer: preset load, 1 s countdown with pause/resume/stop, timed alarm gating the LED sweep.
// Optional feature: define SNOOZE_EN to let btn_snooze re-arm a short countdown from ALARM.
module countdown_alarm_ctrl #(
  parameter int TICK_CYCLES = 100000000,
  parameter int CNT_W       = 8,
  parameter int ALARM_SECS  = 10,
  parameter int SNOOZE_SECS = 5
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             alarm_ack,
  input  logic             btn_snooze,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       state,
  output logic             tick,
  output logic             alarm_active,
  output logic             led_en
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [PW-1:0]    PRE_MAX  = PW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0]    ALM_LAST = AW'(ALARM_SECS - 1);
  localparam logic [CNT_W-1:0] SNZ_VAL  = CNT_W'(SNOOZE_SECS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [PW-1:0]    r_presc;
  logic [AW-1:0]    r_atmr;
  logic             r_alarm;
  logic             r_led;
  logic             w_tick;
  logic             w_snooze;

  assign w_tick = ((r_state == S_RUN) || (r_state == S_ALARM)) && (r_presc == PRE_MAX);

`ifdef SNOOZE_EN
  assign w_snooze = btn_snooze;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = btn_snooze;
  assign w_snooze        = 1'b0;
`endif

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_presc     <= '0;
      r_atmr      <= '0;
      r_alarm     <= 1'b0;
      r_led       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (btn_start && (load_val != '0)) begin
            r_state     <= S_RUN;
            r_remaining <= load_val;
            r_presc     <= '0;
          end
        end

        S_RUN: begin
          if (btn_stop) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_presc     <= '0;
          end else if (btn_start) begin
            // prescaler is frozen here so resume continues mid-second
            r_state <= S_PAUSE;
          end else if (w_tick) begin
            r_presc <= '0;
            if (r_remaining <= CNT_W'(1)) begin
              r_remaining <= '0;
              r_state     <= S_ALARM;
              r_atmr      <= '0;
              r_alarm     <= 1'b1;
              r_led       <= 1'b1;
            end else begin
              r_remaining <= r_remaining - 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end

        S_PAUSE: begin
          if (btn_stop) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_presc     <= '0;
          end else if (btn_start) begin
            r_state <= S_RUN;
          end
        end

        S_ALARM: begin
          if (btn_stop || alarm_ack) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_atmr  <= '0;
            r_alarm <= 1'b0;
            r_led   <= 1'b0;
          end else if (w_snooze) begin
            r_state     <= S_RUN;
            r_remaining <= SNZ_VAL;
            r_presc     <= '0;
            r_atmr      <= '0;
            r_alarm     <= 1'b0;
            r_led       <= 1'b0;
          end else if (w_tick) begin
            r_presc <= '0;
            if (r_atmr == ALM_LAST) begin
              r_state <= S_IDLE;
              r_atmr  <= '0;
              r_alarm <= 1'b0;
              r_led   <= 1'b0;
            end else begin
              r_atmr <= r_atmr + 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state        = r_state;
  assign remaining    = r_remaining;
  assign tick         = w_tick;
  assign alarm_active = r_alarm;
  assign led_en       = r_led;

endmodule

// File: tb/tb_countdown_alarm_ctrl.sv
// Bench for countdown_alarm_ctrl: directed scenarios plus random button traffic against a cycle-level model.
module tb_countdown_alarm_ctrl;
  localparam int TC    = 4;
  localparam int CW    = 8;
  localparam int AS    = 3;
  localparam int SS    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_start = 1'b0, btn_stop = 1'b0, alarm_ack = 1'b0, btn_snooze = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic [CW-1:0] remaining;
  logic [1:0]    state;
  logic          tick, alarm_active, led_en;

  countdown_alarm_ctrl #(.TICK_CYCLES(TC), .CNT_W(CW), .ALARM_SECS(AS), .SNOOZE_SECS(SS)) dut (
    .clk_100mhz(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop(btn_stop),
    .alarm_ack(alarm_ack), .btn_snooze(btn_snooze), .load_val(load_val),
    .remaining(remaining), .state(state), .tick(tick),
    .alarm_active(alarm_active), .led_en(led_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: mode 0 idle / 1 counting / 2 paused / 3 alarm; phase = cycles into the current second
  int m_mode = 0, m_rem = 0, m_phase = 0, m_secs = 0;
`ifdef SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return (m_mode == 1 || m_mode == 3) && (m_phase == TC - 1);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_rem = 0; m_phase = 0; m_secs = 0;
  endtask

  task automatic m_step(input bit st, input bit sp, input bit ak, input bit sz, input int lv);
    bit t;
    t = m_tick();
    case (m_mode)
      0: if (st && lv != 0) begin m_mode = 1; m_rem = lv; m_phase = 0; end
      1: if (sp) begin m_mode = 0; m_rem = 0; m_phase = 0; end
         else if (st) m_mode = 2;
         else if (t) begin
           m_phase = 0;
           m_rem = m_rem - 1;
           if (m_rem == 0) begin m_mode = 3; m_secs = 0; end
         end else m_phase++;
      2: if (sp) begin m_mode = 0; m_rem = 0; m_phase = 0; end
         else if (st) m_mode = 1;
      default:
         if (sp || ak) begin m_mode = 0; m_phase = 0; end
         else if (sz && SNZ) begin m_mode = 1; m_rem = SS; m_phase = 0; m_secs = 0; end
         else if (t) begin
           m_phase = 0;
           m_secs++;
           if (m_secs == AS) m_mode = 0;
         end else m_phase++;
    endcase
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, int'(state), m_mode);
    chk({tag, ".rem"},   int'(remaining), m_rem);
    chk({tag, ".tick"},  int'(tick), int'(m_tick()));
    chk({tag, ".alarm"}, int'(alarm_active), int'(m_mode == 3));
    chk({tag, ".led"},   int'(led_en), int'(m_mode == 3));
  endtask

  // one clock: drive pulses, advance model, check just after the edge
  task automatic cyc(input string tag, input bit st, input bit sp, input bit ak, input bit sz, input int lv);
    @(negedge clk);
    btn_start = st; btn_stop = sp; alarm_ack = ak; btn_snooze = sz; load_val = CW'(lv);
    m_step(st, sp, ak, sz, lv);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #2;
    chk("rst.state", int'(state), 0);
    chk("rst.rem", int'(remaining), 0);
    chk("rst.tick", int'(tick), 0);
    chk("rst.alarm", int'(alarm_active), 0);
    chk("rst.led", int'(led_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    do_reset();

    // 3 s countdown, alarm latency from start edge is 3 seconds of TC cycles
    cyc("ld3", 1, 0, 0, 0, 3);
    chk("ld3.rem0", int'(remaining), 3);
    lat = 0;
    for (int i = 0; i < 20 && !alarm_active; i++) begin
      idle("ld3", 1);
      lat++;
    end
    chk("ld3.alarm_lat", lat, 3 * TC);
    chk("ld3.led_on", int'(led_en), 1);
    idle("alm_timeout", AS * TC - 1);
    chk("alm.still_on", int'(alarm_active), 1);
    idle("alm_timeout", 1);
    chk("alm.timeout_state", int'(state), 0);
    chk("alm.timeout_off", int'(alarm_active), 0);

    // pause holds remaining and prescaler
    cyc("pz", 1, 0, 0, 0, 5);
    idle("pz", 6);
    cyc("pz.pause", 1, 0, 0, 0, 0);
    idle("pz.hold", 20);
    chk("pz.rem_held", int'(remaining), 4);
    chk("pz.state", int'(state), 2);
    cyc("pz.resume", 1, 0, 0, 0, 0);
    idle("pz.run", 3);
    cyc("pz.stop", 0, 1, 0, 0, 0);

    // stop wins over the final tick
    cyc("sf", 1, 0, 0, 0, 1);
    idle("sf", TC - 1);
    chk("sf.tick_now", int'(tick), 1);
    cyc("sf.stop", 0, 1, 0, 0, 0);
    chk("sf.state", int'(state), 0);
    chk("sf.alarm", int'(alarm_active), 0);
    idle("sf.after", 2 * TC);

    // zero preset ignored
    cyc("z", 1, 0, 0, 0, 0);
    chk("z.state", int'(state), 0);

    // ack clears alarm; snooze behaviour follows build option
    cyc("ak", 1, 0, 0, 0, 1);
    idle("ak", TC);
    cyc("ak.ack", 0, 0, 1, 0, 0);
    chk("ak.off", int'(alarm_active), 0);
    cyc("sn", 1, 0, 0, 0, 1);
    idle("sn", TC);
    cyc("sn.snooze", 0, 0, 0, 1, 0);
    idle("sn.after", 2 * TC + 2);
    cyc("sn.stop", 0, 1, 0, 0, 0);

    // async reset mid-run
    cyc("ar", 1, 0, 0, 0, 9);
    idle("ar", 6);
    do_reset();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit st, sp, ak, sz;
      int lv;
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 39) == 0);
      ak = ($urandom_range(0, 19) == 0);
      sz = ($urandom_range(0, 14) == 0);
      lv = $urandom_range(0, 6);
      cyc("rnd", st, sp, ak, sz, lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
